gps_wb_chan_fabric: RTL

GPS_WB_CHAN_FABRIC -- requirements
Module: gps_wb_chan_fabric

---
 rtl/gps_wb_pkg.sv | 29 ++
 rtl/gps_wb_timeout.sv | 40 ++++
 rtl/gps_wb_chan_fabric.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/gps_wb_pkg.sv
// Shared definitions for the GPS Wishbone channel fabric.
//   state_e   : fabric FSM states
//   CntW      : width of the timeout and error counters
//   Reg*      : local status page register offsets
//   IdTag     : upper half of the ID register
//   id_word() : builds the ID register value for a given channel count
package gps_wb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StChWait,
    StResp,
    StErr
  } state_e;

  localparam int unsigned CntW = 16;

  localparam logic [7:0] RegId     = 8'h00;
  localparam logic [7:0] RegEnMask = 8'h04;
  localparam logic [7:0] RegErrCnt = 8'h08;
  localparam logic [7:0] RegErrAdr = 8'h0C;

  localparam logic [15:0] IdTag = 16'hC4A5;

  function automatic logic [31:0] id_word(input int unsigned num_ch);
    return {IdTag, 8'd0, num_ch[7:0]};
  endfunction

endpackage

// File: rtl/gps_wb_timeout.sv
// Cycle timeout counter, reusable by any bus block that waits on a slave.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : clear the count (takes priority over en)
//   en         : count one waiting cycle
//   expire     : high during the Limit-th enabled cycle after a load
module gps_wb_timeout
  import gps_wb_pkg::*;
#(
  parameter int unsigned Limit = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of completed wait cycles, so the current one is cnt_q+1.
  assign expire = en && (cnt_q == CntW'(Limit - 1));

endmodule

// File: rtl/gps_wb_chan_fabric.sv
// Wishbone fabric fanning one master out to NUM_CH tracking channels plus a
// local status page (ID, EN_MASK, ERR_CNT, ERR_ADR). One transfer in flight.
//   wb_*     : master side (clock, async active-low reset, cyc/stb/we/adr/dat, ack/err)
//   ch_stb_o : one-hot channel strobe; ch_cyc/we/adr/dat_o shared by all channels
//   ch_dat_i : channel n read data in bits [32n+31:32n]; ch_ack_i per-channel acks
module gps_wb_chan_fabric
  import gps_wb_pkg::*;
#(
  parameter int unsigned NUM_CH      = 8,
  parameter logic [23:0] BASE_PAGE   = 24'h00000A,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  input  logic                   wb_we_i,
  input  logic [31:0]            wb_adr_i,
  input  logic [31:0]            wb_dat_i,
  output logic [31:0]            wb_dat_o,
  output logic                   wb_ack_o,
  output logic                   wb_err_o,
  output logic [NUM_CH-1:0]      ch_stb_o,
  output logic                   ch_cyc_o,
  output logic                   ch_we_o,
  output logic [7:0]             ch_adr_o,
  output logic [31:0]            ch_dat_o,
  input  logic [32*NUM_CH-1:0]   ch_dat_i,
  input  logic [NUM_CH-1:0]      ch_ack_i
);

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] ch_stb_q, ch_stb_d;
  logic [NUM_CH-1:0] en_mask_q;
  logic [CntW-1:0]   err_cnt_q, err_cnt_d;
  logic [31:0]       err_adr_q, adr_q, dat_q, rdata_q;
  logic              we_q;

  logic [23:0]       page, rel;
  logic              req, hit_ch, hit_local, ch_en, sel_ack, expire, loc_wr;
  logic [NUM_CH-1:0] dec_sel;
  logic [31:0]       loc_rdata, ack_dat;

  // Page decode; the page >= BASE_PAGE term guards against rel wrapping.
  assign page      = wb_adr_i[31:8];
  assign rel       = page - BASE_PAGE;
  assign req       = wb_cyc_i & wb_stb_i;
  assign hit_ch    = (page >= BASE_PAGE) && (rel < 24'(NUM_CH));
  assign hit_local = (page >= BASE_PAGE) && (rel == 24'(NUM_CH));

  always_comb begin
    dec_sel = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      dec_sel[n] = hit_ch && (rel == 24'(n));
    end
  end

  assign ch_en   = |(dec_sel & en_mask_q);
  assign sel_ack = |(ch_ack_i & ch_stb_q);
  assign loc_wr  = (state_q == StIdle) && req && hit_local && wb_we_i;

  always_comb begin
    loc_rdata = '0;
    case (wb_adr_i[7:0])
      RegId:     loc_rdata = id_word(NUM_CH);
      RegEnMask: loc_rdata[NUM_CH-1:0] = en_mask_q;
      RegErrCnt: loc_rdata[CntW-1:0] = err_cnt_q;
      RegErrAdr: loc_rdata = err_adr_q;
      default:   ;
    endcase
  end

  // Only the strobed channel's data can reach the response register.
  always_comb begin
    ack_dat = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (ch_stb_q[n]) ack_dat |= ch_dat_i[32*n +: 32];
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_stb_d = ch_stb_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          if (hit_ch && ch_en) begin
            state_d  = StChWait;
            ch_stb_d = dec_sel;
          end else if (hit_local) begin
            state_d = StResp;
          end else begin
            state_d = StErr;
          end
        end
      end
      StChWait: begin
        // Abort beats a same-cycle ack; an ack beats a same-cycle timeout.
        if (!wb_cyc_i) begin
          state_d  = StIdle;
          ch_stb_d = '0;
        end else if (sel_ack) begin
          state_d  = StResp;
          ch_stb_d = '0;
        end else if (expire) begin
          state_d  = StErr;
          ch_stb_d = '0;
        end
      end
      StResp, StErr: state_d = StIdle;
      default: begin
        state_d  = StIdle;
        ch_stb_d = '0;
      end
    endcase
  end

  // A clear written to ERR_CNT wins over a simultaneous error count.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (loc_wr && (wb_adr_i[7:0] == RegErrCnt)) begin
      err_cnt_d = '0;
    end else if ((state_q == StErr) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= StIdle;
      ch_stb_q  <= '0;
      en_mask_q <= '1;
      err_cnt_q <= '0;
      err_adr_q <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ch_stb_q  <= ch_stb_d;
      err_cnt_q <= err_cnt_d;
      if ((state_q == StIdle) && req) begin
        adr_q   <= wb_adr_i;
        dat_q   <= wb_dat_i;
        we_q    <= wb_we_i;
        rdata_q <= loc_rdata;
      end
      if (loc_wr && (wb_adr_i[7:0] == RegEnMask)) en_mask_q <= wb_dat_i[NUM_CH-1:0];
      if ((state_q == StChWait) && wb_cyc_i && sel_ack) rdata_q <= ack_dat;
      if (state_q == StErr) err_adr_q <= adr_q;
    end
  end

  gps_wb_timeout #(
    .Limit (TIMEOUT_CYC)
  ) u_timeout (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_ni),
    .load   (state_q == StIdle),
    .en     (state_q == StChWait),
    .expire (expire)
  );

  assign wb_ack_o = (state_q == StResp);
  assign wb_err_o = (state_q == StErr);
  assign wb_dat_o = wb_ack_o ? rdata_q : '0;
  assign ch_stb_o = ch_stb_q;
  assign ch_cyc_o = |ch_stb_q;
  assign ch_we_o  = ch_cyc_o & we_q;
  assign ch_adr_o = adr_q[7:0];
  assign ch_dat_o = dat_q;

endmodule
